// File: rtl/tea_core_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tea_core_param: iterative TEA encrypt/decrypt engine with 128-bit key,
// configurable round count, rounds per clock and a masked-compare match flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module tea_core_param #(
  parameter int          ROUNDS      = 32,
  parameter int          UNROLL      = 1,
  parameter logic [63:0] MATCH_VALUE = 64'h0,
  parameter logic [63:0] MATCH_MASK  = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic         mode,
  input  logic [63:0]  data,
  input  logic [127:0] key,
  output logic         rdy,
  output logic         busy,
  output logic         done,
  output logic [63:0]  result,
  output logic         match,
  output logic [127:0] key_out
);

  generate
    if (ROUNDS < 1 || ROUNDS > 64 ||
        (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) ||
        (ROUNDS % UNROLL) != 0) begin : g_bad_params
      $error("tea_core_param: illegal ROUNDS/UNROLL combination");
    end
  endgenerate

  localparam int            N         = ROUNDS / UNROLL;
  localparam int            CW        = $clog2(N + 1);
  localparam logic [CW-1:0] c_LAST    = CW'(N - 1);
  localparam logic [31:0]   c_DELTA   = 32'h9E3779B9;
  // Decrypt walks the key schedule backwards from the final encrypt sum.
  localparam logic [31:0]   c_DEC_SUM = 32'(64'(c_DELTA) * 64'(ROUNDS));

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   v0_q, v0_d;
  logic [31:0]   v1_q, v1_d;
  logic [31:0]   sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic          mode_q, mode_d;

  logic [31:0]   w_v0_rnd, w_v1_rnd, w_sum_rnd;
  logic [31:0]   w_k0, w_k1, w_k2, w_k3;
  logic [63:0]   w_cmp;

  assign w_k0 = key_q[127:96];
  assign w_k1 = key_q[95:64];
  assign w_k2 = key_q[63:32];
  assign w_k3 = key_q[31:0];

  function automatic logic [31:0] tea_f(input logic [31:0] x,
                                        input logic [31:0] s,
                                        input logic [31:0] ka,
                                        input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  // UNROLL rounds chained combinationally within one RUN cycle.
  always_comb begin
    w_v0_rnd  = v0_q;
    w_v1_rnd  = v1_q;
    w_sum_rnd = sum_q;
    for (int r = 0; r < UNROLL; r++) begin
      if (mode_q) begin
        w_sum_rnd = w_sum_rnd + c_DELTA;
        w_v0_rnd  = w_v0_rnd + tea_f(w_v1_rnd, w_sum_rnd, w_k0, w_k1);
        w_v1_rnd  = w_v1_rnd + tea_f(w_v0_rnd, w_sum_rnd, w_k2, w_k3);
      end else begin
        w_v1_rnd  = w_v1_rnd - tea_f(w_v0_rnd, w_sum_rnd, w_k2, w_k3);
        w_v0_rnd  = w_v0_rnd - tea_f(w_v1_rnd, w_sum_rnd, w_k0, w_k1);
        w_sum_rnd = w_sum_rnd - c_DELTA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = c_RUN;
      c_RUN:   if (cnt_q == c_LAST) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    rdy  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      c_IDLE:  rdy = 1'b1;
      c_RUN:   busy = 1'b1;
      c_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: rdy = 1'b0;
    endcase
  end

  always_comb begin
    v0_d   = v0_q;
    v1_d   = v1_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    mode_d = mode_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          v0_d   = data[63:32];
          v1_d   = data[31:0];
          key_d  = key;
          mode_d = mode;
          cnt_d  = '0;
          sum_d  = mode ? 32'h0 : c_DEC_SUM;
        end
      end
      c_RUN: begin
        v0_d  = w_v0_rnd;
        v1_d  = w_v1_rnd;
        sum_d = w_sum_rnd;
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q   <= '0;
      v1_q   <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
    end else if (ena) begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      mode_q <= mode_d;
    end
  end

  assign result  = {v0_q, v1_q};
  assign key_out = key_q;
  assign w_cmp   = (result ^ MATCH_VALUE) & MATCH_MASK;
  assign match   = done & (w_cmp == 64'h0);

endmodule
`default_nettype wire

// File: tb/tb_tea_core_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tea_core_param: scoreboard bench for two builds (UNROLL=1 and UNROLL=4).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tea_core_param;

  localparam logic [63:0] c_MB_VAL  = 64'h41EA3A0A_00000000;
  localparam logic [63:0] c_MB_MASK = 64'hFFFFFFFF_00000000;
  localparam logic [31:0] c_DELTA   = 32'h9E3779B9;
  localparam logic [63:0] c_ZERO_CT = 64'h41EA3A0A_94BAA940;

  logic         clk = 1'b0;
  logic         rst, ena, start_a, start_b, mode;
  logic [63:0]  data;
  logic [127:0] key;
  logic         rdy_a, busy_a, done_a, match_a;
  logic         rdy_b, busy_b, done_b, match_b;
  logic [63:0]  result_a, result_b;
  logic [127:0] key_out_a, key_out_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0]  res;
    logic         mt;
    logic [127:0] k;
    int           lat;
  } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  tea_core_param #(.ROUNDS(32), .UNROLL(1), .MATCH_VALUE(64'h0),
                   .MATCH_MASK({64{1'b1}})) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .start(start_a), .mode(mode),
    .data(data), .key(key), .rdy(rdy_a), .busy(busy_a), .done(done_a),
    .result(result_a), .match(match_a), .key_out(key_out_a));

  tea_core_param #(.ROUNDS(32), .UNROLL(4), .MATCH_VALUE(c_MB_VAL),
                   .MATCH_MASK(c_MB_MASK)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .start(start_b), .mode(mode),
    .data(data), .key(key), .rdy(rdy_b), .busy(busy_b), .done(done_b),
    .result(result_b), .match(match_b), .key_out(key_out_b));

  function automatic logic [31:0] f_ref(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  function automatic logic [63:0] tea_ref(input bit enc, input logic [63:0] d,
                                          input logic [127:0] k, input int rounds);
    logic [31:0] v0, v1, s;
    v0 = d[63:32];
    v1 = d[31:0];
    s  = enc ? 32'h0 : c_DELTA * 32'(rounds);
    for (int r = 0; r < rounds; r++) begin
      if (enc) begin
        s  = s + c_DELTA;
        v0 = v0 + f_ref(v1, s, k[127:96], k[95:64]);
        v1 = v1 + f_ref(v0, s, k[63:32], k[31:0]);
      end else begin
        v1 = v1 - f_ref(v0, s, k[63:32], k[31:0]);
        v0 = v0 - f_ref(v1, s, k[127:96], k[95:64]);
        s  = s - c_DELTA;
      end
    end
    return {v0, v1};
  endfunction

  function automatic bit exp_match(input bit sel, input logic [63:0] r);
    if (sel) return ((r ^ c_MB_VAL) & c_MB_MASK) == 64'h0;
    return r == 64'h0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the selected DUT idle. Inputs are
  // scrambled and start re-pulsed mid-run; neither may affect the block.
  task automatic run_block(input bit sel, input bit md, input logic [63:0] d,
                           input logic [127:0] k, input int ena_at,
                           input bit hold_done, input logic [63:0] exp_res);
    exp_t e;
    int   cyc;
    bit   seen;
    e.res = exp_res;
    e.mt  = exp_match(sel, exp_res);
    e.k   = k;
    e.lat = (sel ? 9 : 33) + (ena_at > 0 ? 3 : 0);
    if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    mode = md; data = d; key = k;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_a = 1'b0; start_b = 1'b0;
        mode = !md; data = ~d; key = ~k;
      end
      if (cyc == 3) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == 4) begin start_a = 1'b0; start_b = 1'b0; end
      if (ena_at > 0 && cyc == ena_at) ena = 1'b0;
      if (ena_at > 0 && cyc == ena_at + 3) ena = 1'b1;
      seen = sel ? done_b : done_a;
    end
    start_a = 1'b0; start_b = 1'b0; ena = 1'b1;
    chk("done_seen", 128'(seen), 128'(1'b1));
    e = sel ? sb_b.pop_front() : sb_a.pop_front();
    if (seen) begin
      chk("result",  sel ? result_b  : result_a,  e.res);
      chk("match",   sel ? match_b   : match_a,   e.mt);
      chk("key_out", sel ? key_out_b : key_out_a, e.k);
      chk("latency", 128'(cyc), 128'(e.lat));
      if (hold_done) begin
        ena = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("done_stretch", sel ? done_b : done_a, 1'b1);
          chk("result_frozen", sel ? result_b : result_a, e.res);
        end
        ena = 1'b1;
      end
      @(negedge clk);
      chk("done_pulse",  sel ? done_b  : done_a,  1'b0);
      chk("match_low",   sel ? match_b : match_a, 1'b0);
      chk("rdy_after",   sel ? rdy_b   : rdy_a,   1'b1);
      chk("result_hold", sel ? result_b : result_a, e.res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]  d, c, d1;
    logic [127:0] k;
    int           cyc, first, second;
    bit           seen;
    exp_t         e;

    rst = 1'b1; ena = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode = 1'b0; data = '0; key = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy",    rdy_a,    1'b1);
    chk("rst_busy",   busy_a,   1'b0);
    chk("rst_done",   done_a,   1'b0);
    chk("rst_result", result_a, 64'h0);
    chk("rst_match",  match_a,  1'b0);
    chk("rst_key",    key_out_a, 128'h0);
    chk("rst_rdy_b",  rdy_b,    1'b1);
    rst = 1'b0;

    // Known zero-key vector, both directions, both builds.
    run_block(1'b0, 1'b1, 64'h0, 128'h0, 0, 1'b0, c_ZERO_CT);
    run_block(1'b0, 1'b0, c_ZERO_CT, 128'h0, 0, 1'b0, 64'h0);
    run_block(1'b1, 1'b1, 64'h0, 128'h0, 0, 1'b0, c_ZERO_CT);
    run_block(1'b1, 1'b0, c_ZERO_CT, 128'h0, 0, 1'b0, 64'h0);

    // Clock-enable gap mid-run, then ena low while done is up.
    d = 64'h01234567_89ABCDEF;
    k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    run_block(1'b0, 1'b1, d, k, 5, 1'b0, tea_ref(1'b1, d, k, 32));
    run_block(1'b1, 1'b0, d, k, 0, 1'b1, tea_ref(1'b0, d, k, 32));

    // Reset in the tenth RUN cycle.
    mode = 1'b1; data = d; key = k; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdy",    rdy_a,     1'b1);
    chk("midrst_busy",   busy_a,    1'b0);
    chk("midrst_result", result_a,  64'h0);
    chk("midrst_key",    key_out_a, 128'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    chk("no_done_after_rst", 128'(seen), 128'(1'b0));
    run_block(1'b0, 1'b1, d, k, 0, 1'b0, tea_ref(1'b1, d, k, 32));

    // Reset and start together: block must not be accepted.
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk("rststart_rdy", rdy_a, 1'b1);
    @(negedge clk);
    chk("rststart_busy", busy_a, 1'b0);

    // start held high: back-to-back blocks N+2 cycles apart.
    d1 = 64'hDEADBEEF_CAFEF00D;
    c = tea_ref(1'b1, d1, k, 32);
    e.res = c; e.mt = exp_match(1'b1, c); e.k = k; e.lat = 9;
    sb_b.push_back(e);
    sb_b.push_back(e);
    mode = 1'b1; data = d1; key = k; start_b = 1'b1;
    cyc = 0; first = 0; second = 0;
    while (second == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done_b) begin
        e = sb_b.pop_front();
        chk("held_result", result_b, e.res);
        chk("held_match",  match_b,  e.mt);
        if (first == 0) first = cyc; else second = cyc;
      end
    end
    start_b = 1'b0;
    chk("held_first", 128'(first), 128'(9));
    chk("held_gap",   128'(second - first), 128'(10));
    repeat (2) @(negedge clk);
    chk("held_stop_busy", busy_b, 1'b0);
    sb_b.delete();

    // Random round trips.
    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      c = tea_ref(1'b1, d, k, 32);
      run_block(1'b1, 1'b1, d, k, 0, 1'b0, c);
      run_block(1'b1, 1'b0, c, k, 0, 1'b0, d);
    end
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      c = tea_ref(1'b1, d, k, 32);
      run_block(1'b0, 1'b1, d, k, 0, 1'b0, c);
      run_block(1'b0, 1'b0, c, k, 0, 1'b0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
